uart_rx_os16: RTL
=================

Name: uart_rx_os16

Overview:
- 8-bit asynchronous serial receiver using 16x oversampling; the receive-side counterpart of the team's start/8-data/stop, LSB-first transmitter.
- Sits between the board RX pin and the byte-consuming logic.
- Synchronises the pin, validates the start bit at mid-bit, samples each data bit at its centre and checks the stop bit.
- Hands each byte off on a valid/ready handshake, with framing and overrun flags.

Parameters:
- CLK_FREQ, 125_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- DIV, (CLK_FREQ + 8*BAUD)/(16*BAUD): clocks per oversample tick, rounded to nearest. Must be >= 1.
- PARITY_ODD, 0: parity sense when UART_RX_PARITY_EN is defined. 0 = even, 1 = odd.

Ports:
- clk, input, 1: system clock; all logic is on its rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- rxd, input, 1: raw serial line; idles high.
- rx_data, output, 8: received byte; stable while rx_valid=1.
- rx_valid, output, 1: byte available.
- rx_ready, input, 1: consumer accepts the byte in any cycle where rx_valid & rx_ready.
- frame_err, output, 1: 1-clk pulse when the stop bit is sampled as 0.
- parity_err, output, 1: 1-clk pulse on parity mismatch; constant 0 without UART_RX_PARITY_EN.
- overrun, output, 1: 1-clk pulse when a new byte completes while the previous one is unaccepted.
- busy, output, 1: high whenever the FSM is not IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Synchroniser flops = 1.
  - rx_data = 8'h00, rx_valid = 0, all flags = 0, busy = 0.
  - FSM = IDLE; tick counter and oversample counter = 0.
  - Reset mid-frame discards the partial byte; the next frame starts clean.
- Input: rxd passes through a 2-FF synchroniser giving rxd_s (2-clk latency). rxd_s_d is rxd_s delayed one clock.
- Tick generator:
  - Counts 0..DIV-1 and emits a 1-clk tick at DIV-1.
  - Is cleared on the IDLE-to-START transition, so bit timing is phase-aligned to the start edge.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - rxd_s_d=1 and rxd_s=0 (falling edge) goes to START; os_cnt=0.
  - Because the edge needs a prior high, a line held low (break) never retriggers.
- START:
  - On the 8th tick (os_cnt reaches 7), sample rxd_s.
  - Sample = 1: false start. Go to IDLE with no flags.
  - Sample = 0: go to DATA with os_cnt=0 and bit_cnt=0.
- DATA:
  - Every 16th tick, shift rxd_s into the shift register, LSB first (bit_cnt 0..7).
  - After bit 7, go to PARITY (macro defined) or STOP.
- PARITY: sampled after 16 ticks, then go to STOP.
- STOP: sampled after 16 ticks, then go to IDLE in the same cycle.
  - Stop = 0: frame_err pulses and the byte is discarded.
  - Parity mismatch: parity_err pulses and the byte is discarded. Checked independently, so both flags may pulse together.
  - Good frame: see output register below.
- Output register:
  - A good frame loads rx_data and sets rx_valid on the clock after the stop-sample tick.
  - rx_valid clears on the clock after rx_valid & rx_ready.
  - New good byte with rx_valid=1 and rx_ready=0 that cycle: overrun pulses, the new byte is dropped, and rx_data/rx_valid are unchanged.
  - New good byte in the same cycle as an accept: no overrun; the new byte is loaded and rx_valid stays 1.
- Timing: total latency from the rxd start edge to rx_valid is about (9.5 bits x 16 x DIV) + 3 clk; 10.5 bits with parity.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the PARITY state is present and expects one parity bit between data bit 7 and the stop bit. Parity is even (PARITY_ODD=0) or odd. A mismatch pulses parity_err and drops the byte.
- Undefined: 8N1 frame only; no PARITY state; parity_err is tied to 0.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum uart_rx_state_t (IDLE, START, DATA, PARITY, STOP).
  - Constants OS_RATE=16, OS_MID=7, DATA_BITS=8.
  - Function computing DIV from CLK_FREQ and BAUD.
- Sub-module uart_baud_tick: parameterised DIV, synchronous clear input, 1-clk tick output. The transmitter can reuse it.

Test Plan:
1. CLK_FREQ=6_400_000, BAUD=100_000 (DIV=4, 64 clk/bit), rx_ready=1, send 0xA5 as 8N1 -> rx_valid pulses once, rx_data=0xA5, frame_err=0, busy back to 0 after the stop bit.
2. Drive rxd low for 20 clk then high -> busy high for about 32 clk, no rx_valid, no flags, FSM back in IDLE.
3. Send 0x3C with stop bit = 0 -> frame_err 1-clk pulse, rx_valid stays 0. Hold rxd low for 2 bit times, then send 0x81 -> only 0x81 is received, once.
4. rx_ready=0, send 0x11 then 0x22 -> rx_valid=1 with 0x11, overrun pulses at the end of 0x22, rx_data stays 0x11. Raise rx_ready for 1 clk -> rx_valid=0 on the next clk.
5. Pulse reset_n low during data bit 4 of 0x5A -> all outputs 0 immediately. Release and send 0xC3 -> rx_data=0xC3, no flags.
6. With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x07 with parity bit 0 (expected 1) -> parity_err pulse, no rx_valid. Resend with parity bit 1 -> rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and the
// baud divisor helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int OS_RATE   = 16;
  localparam int OS_MID    = 7;
  localparam int DATA_BITS = 8;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input longint clk_freq, input longint baud);
    return int'((clk_freq + 8 * baud) / (16 * baud));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divide-by-DIV tick generator with synchronous clear; shared by
// the UART receiver and transmitter.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling 8-bit UART receiver with valid/ready byte hand-off, framing
// and overrun flags. Define UART_RX_PARITY_EN to expect a parity bit (8E1/8O1).
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int BAUD       = 9600,
  parameter int DIV        = calc_div(CLK_FREQ, BAUD),
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  uart_rx_state_t state, state_next;

  logic       rxd_meta, rxd_s, rxd_s_d;
  logic       tick, tick_clr;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       os_clr, os_inc, bit_clr, shift_en, par_en, stop_en;
  logic       par_bad, good;

  // Synchroniser plus one extra stage for start-edge detection; idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_s_d  <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_s_d  <= rxd_s;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tick_clr),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tick_clr   = 1'b0;
    os_clr     = 1'b0;
    os_inc     = 1'b0;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    case (state)
      IDLE: begin
        if (rxd_s_d && !rxd_s) begin
          state_next = START;
          tick_clr   = 1'b1;
          os_clr     = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt == 4'(OS_MID)) begin
            os_clr  = 1'b1;
            bit_clr = 1'b1;
            state_next = rxd_s ? IDLE : DATA;
          end else begin
            os_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_cnt == 4'(OS_RATE - 1)) begin
            os_clr   = 1'b1;
            shift_en = 1'b1;
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end else begin
            os_inc = 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (os_cnt == 4'(OS_RATE - 1)) begin
            os_clr     = 1'b1;
            par_en     = 1'b1;
            state_next = STOP;
          end else begin
            os_inc = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (os_cnt == 4'(OS_RATE - 1)) begin
            stop_en    = 1'b1;
            state_next = IDLE;
          end else begin
            os_inc = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic parity_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      if (par_en) begin
        par_bit <= rxd_s;
      end
      parity_err_q <= stop_en && par_bad;
    end
  end

  // Even parity: data plus parity bit XOR to 0; odd parity: to 1.
  assign par_bad    = ((^shift_reg) ^ par_bit) != PARITY_ODD;
  assign parity_err = parity_err_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign good = stop_en && rxd_s && !par_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_en && !rxd_s;
      overrun   <= 1'b0;
      if (os_clr) begin
        os_cnt <= '0;
      end else if (os_inc) begin
        os_cnt <= os_cnt + 4'd1;
      end
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_en) begin
        shift_reg <= {rxd_s, shift_reg[7:1]};
      end
      // An unaccepted byte is never overwritten; an accept in the same cycle frees the slot.
      if (good) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
